// File: rtl/pipe_mem_pkg.sv
// Shared types and width-select codes for the MEM-stage data-memory access path.
package pipe_mem_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BE_W    = XLEN / 8;
    localparam int unsigned SEL_W   = 3;

    // Load/store width-select encodings driven by decode
    localparam logic [SEL_W-1:0] SEL_WORD = 3'd0;
    localparam logic [SEL_W-1:0] SEL_HALF = 3'd1;
    localparam logic [SEL_W-1:0] SEL_BYTE = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        WIDTH_WORD,
        WIDTH_HALF,
        WIDTH_BYTE
    } width_e;

    // Access parameters captured at start and used for the rest of the access
    typedef struct packed {
        logic [1:0]       addr_lo;
        logic [SEL_W-1:0] sel;
        logic             sign;
        logic             is_store;
    } mem_req_t;

    // Registered data-bus request payload
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } mem_bus_t;

    // Unused select codes fall back to a full-word access
    function automatic width_e decode_width(input logic [SEL_W-1:0] sel);
        width_e w;
        case (sel)
            SEL_HALF: w = WIDTH_HALF;
            SEL_BYTE: w = WIDTH_BYTE;
            default:  w = WIDTH_WORD;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_lane_format.sv
// Combinational lane formatting: store lane replication / byte enables,
// load byte/half extraction with extension, and alignment check.
module mem_lane_format
    import pipe_mem_pkg::*;
(
    input  logic [1:0]       addr_lo,
    input  logic             is_store,
    input  logic [SEL_W-1:0] store_sel,
    input  logic [SEL_W-1:0] load_sel,
    input  logic [XLEN-1:0]  store_data,
    output logic             misaligned,
    output logic [BE_W-1:0]  be,
    output logic [XLEN-1:0]  wdata,
    input  logic [1:0]       ld_addr_lo,
    input  logic [SEL_W-1:0] ld_sel,
    input  logic             ld_sign,
    input  logic [XLEN-1:0]  rdata,
    output logic [XLEN-1:0]  load_data
);

    width_e st_w;
    width_e acc_w;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign st_w  = decode_width(store_sel);
    assign acc_w = is_store ? st_w : decode_width(load_sel);

    // Word must sit on a 4-byte boundary, half on a 2-byte boundary
    always_comb begin
        misaligned = 1'b0;
        case (acc_w)
            WIDTH_HALF: misaligned = addr_lo[0];
            WIDTH_BYTE: misaligned = 1'b0;
            default:    misaligned = |addr_lo;
        endcase
    end

    // Little-endian store lanes; loads always read the full word
    always_comb begin
        be    = 4'b1111;
        wdata = '0;
        if (is_store) begin
            wdata = store_data;
            case (st_w)
                WIDTH_BYTE: begin
                    wdata = {4{store_data[7:0]}};
                    be    = 4'b0001 << addr_lo;
                end
                WIDTH_HALF: begin
                    wdata = {2{store_data[15:0]}};
                    be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: ;
            endcase
        end
    end

    // Pick the addressed byte/half out of the returned word and extend it
    always_comb begin
        case (ld_addr_lo)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (decode_width(ld_sel))
            WIDTH_BYTE: load_data = {{24{ld_sign & byte_v[7]}}, byte_v};
            WIDTH_HALF: load_data = {{16{ld_sign & half_v[15]}}, half_v};
            default:    load_data = rdata;
        endcase
    end

endmodule

// File: rtl/pipe_mem_access.sv
// MEM-stage data-memory access unit: handshaked bus master with pipeline
// stall, load extension, misalignment and timeout reporting.
module pipe_mem_access
    import pipe_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  dmem_addr_i,
    input  logic [XLEN-1:0]  store_data_i,
    input  logic             dmem_wena_i,
    input  logic             dmem_rena_i,
    input  logic             load_sign_i,
    input  logic [SEL_W-1:0] load_select_i,
    input  logic [SEL_W-1:0] store_select_i,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [XLEN-1:0]  bus_addr_o,
    output logic [BE_W-1:0]  bus_be_o,
    output logic [XLEN-1:0]  bus_wdata_o,
    input  logic             bus_ready_i,
    input  logic             bus_rvalid_i,
    input  logic [XLEN-1:0]  bus_rdata_i,
    output logic             stall_o,
    output logic [XLEN-1:0]  load_data_o,
    output logic             load_valid_o,
    output logic             addr_error_o,
    output logic             bus_error_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_d;
    mem_bus_t         bus_q, bus_d;
    logic             bus_req_q, bus_req_d;
    logic [XLEN-1:0]  load_data_q, load_data_d;
    logic             load_valid_q, load_valid_d;
    logic             bus_error_q, bus_error_d;

    logic             start_c;
    logic             misaligned_c;
    logic             timeout_c;
    logic [BE_W-1:0]  fmt_be;
    logic [XLEN-1:0]  fmt_wdata;
    logic [XLEN-1:0]  fmt_load_data;

    // Store side sees the incoming request; load side sees the latched one
    mem_lane_format u_fmt (
        .addr_lo    (dmem_addr_i[1:0]),
        .is_store   (dmem_wena_i),
        .store_sel  (store_select_i),
        .load_sel   (load_select_i),
        .store_data (store_data_i),
        .misaligned (misaligned_c),
        .be         (fmt_be),
        .wdata      (fmt_wdata),
        .ld_addr_lo (req_q.addr_lo),
        .ld_sel     (req_q.sel),
        .ld_sign    (req_q.sign),
        .rdata      (bus_rdata_i),
        .load_data  (fmt_load_data)
    );

    assign start_c   = rst_n & valid_i & (state_q == IDLE) & (dmem_wena_i | dmem_rena_i);
    assign timeout_c = (cnt_q >= CNT_LAST);

    // Same-cycle stall and misalignment flag so the pipeline holds in the start cycle
    assign stall_o      = (start_c & ~misaligned_c) | (state_q == REQ) | (state_q == WAIT);
    assign addr_error_o = start_c & misaligned_c;

    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_q.we;
    assign bus_addr_o   = bus_q.addr;
    assign bus_be_o     = bus_q.be;
    assign bus_wdata_o  = bus_q.wdata;
    assign load_data_o  = load_data_q;
    assign load_valid_o = load_valid_q;
    assign bus_error_o  = bus_error_q;

    // Next-state and next-register values for the access sequencer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        bus_d        = bus_q;
        bus_req_d    = bus_req_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_error_d  = 1'b0;

        if ((state_q == REQ || state_q == WAIT) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_c && !misaligned_c) begin
                    state_d          = REQ;
                    cnt_d            = '0;
                    req_d.addr_lo    = dmem_addr_i[1:0];
                    req_d.sel        = load_select_i;
                    req_d.sign       = load_sign_i;
                    req_d.is_store   = dmem_wena_i;
                    bus_req_d        = 1'b1;
                    bus_d.we         = dmem_wena_i;
                    bus_d.addr       = {dmem_addr_i[XLEN-1:2], 2'b00};
                    bus_d.be         = fmt_be;
                    bus_d.wdata      = fmt_wdata;
                end
            end
            REQ: begin
                if (bus_ready_i) begin
                    bus_req_d = 1'b0;
                    state_d   = req_q.is_store ? DONE : WAIT;
                end else if (timeout_c) begin
                    bus_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    load_data_d = '0;
                    state_d     = DONE;
                end
            end
            WAIT: begin
                if (bus_rvalid_i) begin
                    load_data_d  = fmt_load_data;
                    load_valid_d = 1'b1;
                    state_d      = DONE;
                end else if (timeout_c) begin
                    bus_error_d = 1'b1;
                    load_data_d = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            bus_q        <= '0;
            bus_req_q    <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            bus_q        <= bus_d;
            bus_req_q    <= bus_req_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_error_q  <= bus_error_d;
        end
    end

endmodule

// File: tb/tb_pipe_mem_access.sv
// Scoreboard bench for pipe_mem_access with a small in-bench bus responder.
module tb_pipe_mem_access;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] dmem_addr_i;
    logic [31:0] store_data_i;
    logic        dmem_wena_i;
    logic        dmem_rena_i;
    logic        load_sign_i;
    logic [2:0]  load_select_i;
    logic [2:0]  store_select_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ready_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        addr_error_o;
    logic        bus_error_o;

    localparam logic [2:0] EV_LOAD    = 3'b001;
    localparam logic [2:0] EV_BUSERR  = 3'b010;
    localparam logic [2:0] EV_ADDRERR = 3'b100;

    typedef struct {
        logic [2:0]  kind;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    pipe_mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .dmem_addr_i    (dmem_addr_i),
        .store_data_i   (store_data_i),
        .dmem_wena_i    (dmem_wena_i),
        .dmem_rena_i    (dmem_rena_i),
        .load_sign_i    (load_sign_i),
        .load_select_i  (load_select_i),
        .store_select_i (store_select_i),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_be_o       (bus_be_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_ready_i    (bus_ready_i),
        .bus_rvalid_i   (bus_rvalid_i),
        .bus_rdata_i    (bus_rdata_i),
        .stall_o        (stall_o),
        .load_data_o    (load_data_o),
        .load_valid_o   (load_valid_o),
        .addr_error_o   (addr_error_o),
        .bus_error_o    (bus_error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_ev(input logic [2:0] kind, input logic chk_data, input logic [31:0] data);
        exp_t e;
        e.kind     = kind;
        e.chk_data = chk_data;
        e.data     = data;
        exp_q.push_back(e);
    endtask

    // Pops one expected event per pulse cycle, so wide pulses also show up
    logic [2:0] ev_kind;
    initial begin
        forever begin
            @(negedge clk);
            ev_kind = {addr_error_o, bus_error_o, load_valid_o};
            if (ev_kind != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_event", 32'(ev_kind), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_val("event_kind", 32'(ev_kind), 32'(e.kind));
                    if (e.chk_data) check_val("load_data", load_data_o, e.data);
                end
            end
        end
    end

    // One instruction through MEM with a responder that accepts after rdy_dly
    // request cycles and returns read data the cycle after acceptance.
    task automatic run_access(input string tag, input logic st, input logic ld,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] ssel, input logic [2:0] lsel, input logic sgn,
                              input int rdy_dly, input logic give_rv, input logic [31:0] rdata,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input int e_stall, input int e_req);
        int          stall_n = 0;
        int          req_n   = 0;
        int          hold_n  = 0;
        logic        acc_prev = 1'b0;
        logic        done = 1'b0;
        logic        s_stall, s_req, s_we;
        logic [31:0] s_addr, s_wdata, f_addr, f_wdata;
        logic [3:0]  s_be, f_be;
        logic        f_we;
        f_addr = '0; f_wdata = '0; f_be = '0; f_we = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b1; dmem_wena_i = st; dmem_rena_i = ld;
        dmem_addr_i = addr; store_data_i = data;
        store_select_i = ssel; load_select_i = lsel; load_sign_i = sgn;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            s_stall = stall_o; s_req = bus_req_o; s_we = bus_we_o;
            s_addr = bus_addr_o; s_be = bus_be_o; s_wdata = bus_wdata_o;
            #1;
            if (s_stall) stall_n++;
            bus_rvalid_i = 1'b0;
            if (acc_prev && give_rv) begin
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = rdata;
            end
            acc_prev = 1'b0;
            if (s_req) begin
                req_n++;
                if (req_n == 1) begin
                    f_addr = s_addr; f_be = s_be; f_wdata = s_wdata; f_we = s_we;
                end else if (s_addr != f_addr || s_be != f_be || s_wdata != f_wdata || s_we != f_we) begin
                    hold_n++;
                end
                bus_ready_i = (req_n > rdy_dly);
                acc_prev    = bus_ready_i;
            end else begin
                bus_ready_i = 1'b0;
            end
            if (!s_stall) begin
                valid_i = 1'b0;
                done    = 1'b1;
            end
        end
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
        dmem_wena_i = 1'b0; dmem_rena_i = 1'b0;
        if (!done) begin
            check_val({tag, "_cycle_bound"}, 32'd0, 32'd1);
            valid_i = 1'b0;
        end
        check_val({tag, "_stall_cycles"}, 32'(stall_n), 32'(e_stall));
        check_val({tag, "_req_cycles"}, 32'(req_n), 32'(e_req));
        if (e_req > 0) begin
            check_val({tag, "_bus_addr"}, f_addr, e_addr);
            check_val({tag, "_bus_be"}, 32'(f_be), 32'(e_be));
            check_val({tag, "_bus_we"}, 32'(f_we), 32'(st));
            if (st) check_val({tag, "_bus_wdata"}, f_wdata, e_wdata);
            check_val({tag, "_bus_hold"}, 32'(hold_n), 32'd0);
        end
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; valid_i = 1'b0; dmem_addr_i = '0; store_data_i = '0;
        dmem_wena_i = 1'b0; dmem_rena_i = 1'b0; load_sign_i = 1'b0;
        load_select_i = '0; store_select_i = '0;
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_bus_req", 32'(bus_req_o), 32'd0);
        check_val("rst_stall", 32'(stall_o), 32'd0);
        check_val("rst_bus_addr", bus_addr_o, 32'd0);
        check_val("rst_bus_be", 32'(bus_be_o), 32'd0);
        check_val("rst_load_data", load_data_o, 32'd0);
        check_val("rst_pulses", 32'({load_valid_o, addr_error_o, bus_error_o}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // tag st ld addr data ssel lsel sgn dly rv rdata | e_addr e_be e_wdata stall req
        run_access("sb", 1, 0, 32'h0000_0103, 32'h0000_00A5, 3'd2, 3'd2, 0, 0, 0, 32'h0,
                   32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 2, 1);
        push_ev(EV_LOAD, 1, 32'hFFFF_8001);
        run_access("lh_s", 0, 1, 32'h0000_0202, 32'h0, 3'd1, 3'd1, 1, 0, 1, 32'h8001_1234,
                   32'h0000_0200, 4'b1111, 32'h0, 3, 1);
        push_ev(EV_LOAD, 1, 32'h0000_8001);
        run_access("lh_u", 0, 1, 32'h0000_0202, 32'h0, 3'd1, 3'd1, 0, 0, 1, 32'h8001_1234,
                   32'h0000_0200, 4'b1111, 32'h0, 3, 1);
        push_ev(EV_ADDRERR, 0, 32'h0);
        run_access("lw_mis", 0, 1, 32'h0000_0301, 32'h0, 3'd0, 3'd0, 0, 0, 1, 32'h0,
                   32'h0, 4'b0, 32'h0, 0, 0);
        run_access("sw_dly3", 1, 0, 32'h0000_0400, 32'h1234_5678, 3'd0, 3'd0, 0, 3, 0, 32'h0,
                   32'h0000_0400, 4'b1111, 32'h1234_5678, 5, 4);
        push_ev(EV_BUSERR, 1, 32'h0);
        run_access("lw_tmo", 0, 1, 32'h0000_0500, 32'h0, 3'd0, 3'd0, 0, 0, 0, 32'h0,
                   32'h0000_0500, 4'b1111, 32'h0, 5, 1);
        push_ev(EV_BUSERR, 1, 32'h0);
        run_access("sw_tmo", 1, 0, 32'h0000_0504, 32'h0000_0001, 3'd0, 3'd0, 0, 1000, 0, 32'h0,
                   32'h0000_0504, 4'b1111, 32'h0000_0001, 5, 4);
        push_ev(EV_LOAD, 1, 32'hFFFF_FF80);
        run_access("lb_s", 0, 1, 32'h0000_0601, 32'h0, 3'd2, 3'd2, 1, 0, 1, 32'h0000_8000,
                   32'h0000_0600, 4'b1111, 32'h0, 3, 1);
        push_ev(EV_LOAD, 1, 32'h0000_00AB);
        run_access("lb_u", 0, 1, 32'h0000_0603, 32'h0, 3'd2, 3'd2, 0, 0, 1, 32'hAB00_0000,
                   32'h0000_0600, 4'b1111, 32'h0, 3, 1);
        run_access("sh_hi", 1, 0, 32'h0000_0702, 32'h0000_BEEF, 3'd1, 3'd1, 0, 0, 0, 32'h0,
                   32'h0000_0700, 4'b1100, 32'hBEEF_BEEF, 2, 1);
        push_ev(EV_ADDRERR, 0, 32'h0);
        run_access("sh_mis", 1, 0, 32'h0000_0703, 32'h0000_BEEF, 3'd1, 3'd1, 0, 0, 0, 32'h0,
                   32'h0, 4'b0, 32'h0, 0, 0);
        push_ev(EV_LOAD, 1, 32'h7F00_FF01);
        run_access("ld_sel5", 0, 1, 32'h0000_0904, 32'h0, 3'd5, 3'd5, 1, 0, 1, 32'h7F00_FF01,
                   32'h0000_0904, 4'b1111, 32'h0, 3, 1);
        push_ev(EV_ADDRERR, 0, 32'h0);
        run_access("sel5_mis", 0, 1, 32'h0000_0906, 32'h0, 3'd5, 3'd5, 0, 0, 1, 32'h0,
                   32'h0, 4'b0, 32'h0, 0, 0);
        run_access("both_en", 1, 1, 32'h0000_0A02, 32'h0000_0011, 3'd2, 3'd0, 0, 0, 1, 32'h0,
                   32'h0000_0A00, 4'b0100, 32'h1111_1111, 2, 1);
        push_ev(EV_LOAD, 1, 32'hDEAD_BEEF);
        run_access("lw_dly2", 0, 1, 32'h0000_0800, 32'h0, 3'd0, 3'd0, 0, 2, 1, 32'hDEAD_BEEF,
                   32'h0000_0800, 4'b1111, 32'h0, 5, 3);

        // Enables without valid_i must not start anything
        @(posedge clk); #1;
        dmem_wena_i = 1'b1; dmem_addr_i = 32'h0000_0100; store_select_i = 3'd0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (stall_o || bus_req_o || addr_error_o) bad++;
        end
        dmem_wena_i = 1'b0;
        check_val("novalid_quiet", 32'(bad), 32'd0);

        // Reset while waiting for read data, then a late rvalid/ready
        @(posedge clk); #1;
        valid_i = 1'b1; dmem_rena_i = 1'b1; dmem_addr_i = 32'h0000_0A00;
        load_select_i = 3'd0; load_sign_i = 1'b0;
        @(posedge clk); #1;
        bus_ready_i = 1'b1;
        @(posedge clk); #1;
        bus_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rstw_stall", 32'(stall_o), 32'd0);
        check_val("rstw_bus_addr", bus_addr_o, 32'd0);
        check_val("rstw_load_data", load_data_o, 32'd0);
        check_val("rstw_bus_req", 32'(bus_req_o), 32'd0);
        valid_i = 1'b0; dmem_rena_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus_rvalid_i = 1'b1; bus_ready_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (stall_o || bus_req_o || load_valid_o) bad++;
        end
        bus_rvalid_i = 1'b0; bus_ready_i = 1'b0;
        check_val("post_rst_quiet", 32'(bad), 32'd0);

        repeat (3) @(negedge clk);
        check_val("events_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
